// File: rtl/gsm_cell_release.sv
// Cell-release controller for the GSM switch: multicast reference counts,
// round-robin release arbitration and a free-address FIFO back to the allocator.
module gsm_cell_release #(
  parameter int MWIDTH = 4,
  parameter int AWIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_gsm_wr_en,
  input  logic [AWIDTH-1:0]        i_gsm_cell_addr,
  input  logic [MWIDTH-1:0]        i_gsm_multicast,
  input  logic [MWIDTH-1:0]        i_rel_valid,
  input  logic [MWIDTH*AWIDTH-1:0] i_rel_addr,
  output logic [MWIDTH-1:0]        o_rel_ack,
  input  logic                     i_hmp_rd,
  output logic                     o_hmp_valid,
  output logic [AWIDTH-1:0]        o_hmp_addr,
  output logic                     o_bf_free_flag,
  output logic                     o_err
);
  localparam int DEPTH  = 1 << AWIDTH;
  localparam int CWIDTH = $clog2(MWIDTH + 1);
  localparam int PWIDTH = (MWIDTH > 1) ? $clog2(MWIDTH) : 1;
  localparam logic [AWIDTH:0] FULL = (AWIDTH+1)'(DEPTH);

  logic [CWIDTH-1:0] refcnt   [DEPTH];
  logic [AWIDTH-1:0] fifo_mem [DEPTH];
  logic [AWIDTH-1:0] rd_ptr, wr_ptr;
  logic [AWIDTH:0]   count;
  logic [PWIDTH-1:0] rr;

  logic              gnt_any;
  logic [PWIDTH-1:0] gnt_port;
  logic [AWIDTH-1:0] rel_addr;
  logic [CWIDTH-1:0] rel_cnt;
  logic [CWIDTH-1:0] load_cnt;
  logic              rel_clash, rel_zero, rel_last, rel_dec;
  logic              full, push_ok, push_drop, pop_ok, pop_err;

  // NOTE: every variable driven here gets a default before the search loop,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = '0;
    for (int i = 0; i < MWIDTH; i++) begin
      if (!gnt_any && i_rel_valid[(int'(rr) + i) % MWIDTH]) begin
        gnt_any  = 1'b1;
        gnt_port = PWIDTH'((int'(rr) + i) % MWIDTH);
      end
    end
    o_rel_ack = '0;
    if (gnt_any) o_rel_ack[gnt_port] = 1'b1;
  end

  always_comb begin
    load_cnt = '0;
    for (int i = 0; i < MWIDTH; i++) load_cnt = load_cnt + CWIDTH'(i_gsm_multicast[i]);
  end

  assign rel_addr = i_rel_addr[int'(gnt_port)*AWIDTH +: AWIDTH];
  assign rel_cnt  = refcnt[rel_addr];

  // A load to the address being released wins; the release is dropped as an error.
  assign rel_clash = gnt_any && i_gsm_wr_en && (rel_addr == i_gsm_cell_addr);
  assign rel_zero  = gnt_any && !rel_clash && (rel_cnt == '0);
  assign rel_last  = gnt_any && !rel_clash && (rel_cnt == CWIDTH'(1));
  assign rel_dec   = gnt_any && !rel_clash && (rel_cnt > CWIDTH'(1));

  assign full      = (count == FULL);
  assign push_ok   = rel_last && !full;
  assign push_drop = rel_last && full;
  assign pop_ok    = i_hmp_rd && (count != '0);
  assign pop_err   = i_hmp_rd && (count == '0);

  // NOTE: refcnt must read 0 right out of reset, so it is cleared entry by entry;
  // fifo_mem carries no reset because count alone decides which entries are live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) refcnt[i] <= '0;
    end else begin
      if (rel_last)     refcnt[rel_addr] <= '0;
      else if (rel_dec) refcnt[rel_addr] <= rel_cnt - CWIDTH'(1);
      if (i_gsm_wr_en)  refcnt[i_gsm_cell_addr] <= load_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= rel_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr             <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      o_bf_free_flag <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      if (gnt_any) rr <= (int'(gnt_port) == MWIDTH - 1) ? '0 : gnt_port + PWIDTH'(1);
      if (push_ok) wr_ptr <= wr_ptr + AWIDTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AWIDTH'(1);
      if (push_ok && !pop_ok)      count <= count + (AWIDTH+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AWIDTH+1)'(1);
      o_bf_free_flag <= push_ok;
      o_err          <= o_err | rel_clash | rel_zero | push_drop | pop_err;
    end
  end

  assign o_hmp_valid = (count != '0);
  assign o_hmp_addr  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_gsm_cell_release.sv
// Directed bench for gsm_cell_release: a queue/array model of the release
// rules is compared with the DUT on every falling edge, plus literal checks.
`timescale 1ns/1ps
module tb_gsm_cell_release;
  localparam int MWIDTH = 4;
  localparam int AWIDTH = 7;
  localparam int DEPTH  = 1 << AWIDTH;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     wr_en;
  logic [AWIDTH-1:0]        cell_addr;
  logic [MWIDTH-1:0]        multicast;
  logic [MWIDTH-1:0]        rel_valid;
  logic [MWIDTH*AWIDTH-1:0] rel_addr;
  logic [MWIDTH-1:0]        rel_ack;
  logic                     hmp_rd;
  logic                     hmp_valid;
  logic [AWIDTH-1:0]        hmp_addr;
  logic                     free_flag;
  logic                     err;

  gsm_cell_release #(.MWIDTH(MWIDTH), .AWIDTH(AWIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_gsm_wr_en     (wr_en),
    .i_gsm_cell_addr (cell_addr),
    .i_gsm_multicast (multicast),
    .i_rel_valid     (rel_valid),
    .i_rel_addr      (rel_addr),
    .o_rel_ack       (rel_ack),
    .i_hmp_rd        (hmp_rd),
    .o_hmp_valid     (hmp_valid),
    .o_hmp_addr      (hmp_addr),
    .o_bf_free_flag  (free_flag),
    .o_err           (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer reference counts and a queue of free addresses.
  int m_cnt [DEPTH];
  int m_q [$];
  int m_rr;
  bit m_err;
  bit m_flag;

  function automatic int exp_grant();
    for (int i = 0; i < MWIDTH; i++) begin
      int p = (m_rr + i) % MWIDTH;
      if (rel_valid[p]) return p;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_q.delete();
      m_rr   = 0;
      m_err  = 0;
      m_flag = 0;
    end else begin
      int g, a, sz;
      bit push;
      g = exp_grant();
      a = 0;
      push = 0;
      sz = m_q.size();
      if (g >= 0) begin
        a = int'(rel_addr[g*AWIDTH +: AWIDTH]);
        m_rr = (g + 1) % MWIDTH;
        if (wr_en && a == int'(cell_addr)) m_err = 1;
        else if (m_cnt[a] == 0) m_err = 1;
        else begin
          m_cnt[a] = m_cnt[a] - 1;
          push = (m_cnt[a] == 0);
        end
      end
      if (wr_en) m_cnt[cell_addr] = $countones(multicast);
      if (hmp_rd) begin
        if (sz == 0) m_err = 1;
        else void'(m_q.pop_front());
      end
      m_flag = 0;
      if (push) begin
        if (sz >= DEPTH) m_err = 1;
        else begin
          m_q.push_back(a);
          m_flag = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      int g;
      g = exp_grant();
      check("ack", rel_ack, (g >= 0) ? (1 << g) : 0);
      check("hmp_valid", hmp_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("hmp_addr", hmp_addr, m_q[0]);
      check("free_flag", free_flag, m_flag);
      check("err", err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [MWIDTH-1:0] mc);
    wr_en = 1'b1;
    cell_addr = AWIDTH'(addr);
    multicast = mc;
    tick();
    wr_en = 1'b0;
    multicast = '0;
  endtask

  task automatic set_port(input int p, input int addr);
    rel_valid[p] = 1'b1;
    rel_addr[p*AWIDTH +: AWIDTH] = AWIDTH'(addr);
  endtask

  // Hold a release request until acked (bounded); optionally pop in the first cycle.
  task automatic release_one(input int p, input int addr, input bit pop);
    bit seen = 0;
    set_port(p, addr);
    hmp_rd = pop;
    for (int c = 0; c < 16 && !seen; c++) begin
      #1;
      seen = rel_ack[p];
      tick();
      hmp_rd = 1'b0;
    end
    rel_valid[p] = 1'b0;
    check("ack_timeout", seen, 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    check("reset_err", err, 0);
    check("reset_valid", hmp_valid, 0);
    rst = 1'b0;
  endtask

  int exp_rr [5] = '{1, 2, 4, 8, 1};

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    cell_addr = '0;
    multicast = '0;
    rel_valid = '0;
    rel_addr = '0;
    hmp_rd = 1'b0;
    tick();
    tick();
    check("rst_ack", rel_ack, 0);
    check("rst_valid", hmp_valid, 0);
    check("rst_flag", free_flag, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Unicast recycle
    load(5, 4'b0001);
    set_port(0, 5);
    #1;
    check("t1_ack", rel_ack, 4'b0001);
    tick();
    rel_valid = '0;
    #1;
    check("t1_flag", free_flag, 1);
    check("t1_valid", hmp_valid, 1);
    check("t1_addr", hmp_addr, 5);
    hmp_rd = 1'b1;
    tick();
    hmp_rd = 1'b0;
    #1;
    check("t1_empty", hmp_valid, 0);
    check("t1_flag_low", free_flag, 0);

    // Multicast count of three
    load(9, 4'b1011);
    release_one(0, 9, 0);
    #1;
    check("t2_flag0", free_flag, 0);
    release_one(1, 9, 0);
    #1;
    check("t2_flag1", free_flag, 0);
    check("t2_valid1", hmp_valid, 0);
    release_one(3, 9, 0);
    #1;
    check("t2_flag3", free_flag, 1);
    check("t2_addr", hmp_addr, 9);
    hmp_rd = 1'b1;
    tick();
    hmp_rd = 1'b0;

    // Round-robin: all ports held, port 0 re-requests with a new address
    for (int p = 0; p < MWIDTH; p++) load(20 + p, MWIDTH'(1 << p));
    load(24, 4'b0001);
    for (int p = 0; p < MWIDTH; p++) set_port(p, 20 + p);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_rr", rel_ack, exp_rr[k]);
      tick();
      if (k == 0) set_port(0, 24);
      else if (k < 4) rel_valid[k] = 1'b0;
      else rel_valid[0] = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_order", hmp_addr, 20 + k);
      hmp_rd = 1'b1;
      tick();
      hmp_rd = 1'b0;
    end
    #1;
    check("t3_empty", hmp_valid, 0);

    // Load and release of the same address in one cycle: load wins, error raised
    load(60, 4'b0001);
    wr_en = 1'b1;
    cell_addr = 7'd60;
    multicast = 4'b0011;
    set_port(1, 60);
    tick();
    wr_en = 1'b0;
    multicast = '0;
    rel_valid = '0;
    #1;
    check("t4_clash_err", err, 1);
    check("t4_clash_flag", free_flag, 0);
    release_one(0, 60, 0);
    release_one(1, 60, 0);
    #1;
    check("t4_clash_cnt2", hmp_addr, 60);
    hmp_rd = 1'b1;
    tick();
    hmp_rd = 1'b0;
    pulse_reset();

    // Release of a zero count, then a pop while empty
    release_one(2, 40, 0);
    #1;
    check("t4_zero_err", err, 1);
    check("t4_zero_flag", free_flag, 0);
    hmp_rd = 1'b1;
    tick();
    hmp_rd = 1'b0;
    #1;
    check("t4_pop_err", err, 1);
    check("t4_pop_valid", hmp_valid, 0);
    pulse_reset();

    // Push and pop together on a FIFO of three; load of another address alongside
    load(50, 4'b0010);
    load(51, 4'b0010);
    load(52, 4'b0010);
    release_one(1, 50, 0);
    release_one(1, 51, 0);
    wr_en = 1'b1;
    cell_addr = 7'd53;
    multicast = 4'b0010;
    release_one(1, 52, 0);
    wr_en = 1'b0;
    multicast = '0;
    #1;
    check("t5_head", hmp_addr, 50);
    release_one(1, 53, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_order", hmp_addr, 51 + k);
      hmp_rd = 1'b1;
      tick();
      hmp_rd = 1'b0;
    end
    #1;
    check("t5_empty", hmp_valid, 0);
    check("t5_err", err, 0);

    // Pointer wrap: 130 recycles with a pop on every odd one
    for (int i = 0; i < 130; i++) begin
      load(i % DEPTH, MWIDTH'(1 << (i % MWIDTH)));
      release_one(i % MWIDTH, i % DEPTH, (i % 2) == 1);
    end
    #1;
    check("t6_head", hmp_addr, 65);
    for (int k = 0; k < 65; k++) begin
      hmp_rd = 1'b1;
      tick();
      hmp_rd = 1'b0;
    end
    #1;
    check("t6_drained", hmp_valid, 0);

    // Asynchronous reset between clock edges
    release_one(1, 71, 0);
    load(70, 4'b0001);
    release_one(0, 70, 0);
    #1;
    check("t7_pre_flag", free_flag, 1);
    check("t7_pre_err", err, 1);
    rst = 1'b1;
    #1;
    check("t7_ack", rel_ack, 0);
    check("t7_valid", hmp_valid, 0);
    check("t7_flag", free_flag, 0);
    check("t7_err", err, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t7_after", hmp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
